// File: rtl/maquina_pkg.sv
// Shared encodings for the coffee-machine arbiter: drink selections,
// arbiter states and the default watchdog limit.
package maquina_pkg;

    typedef enum logic [2:0] {
        CAFE_NINGUNO   = 3'b000,
        CAFE_NEGRO     = 3'b001,
        CAFE_AMERICANO = 3'b010,
        CAFE_LATTE     = 3'b011,
        CAFE_CAPUCHINO = 3'b100
    } tipo_cafe_t;

    typedef enum logic [1:0] {
        TAM_NINGUNO = 2'b00,
        TAM_CHICO   = 2'b01,
        TAM_MEDIANO = 2'b10,
        TAM_GRANDE  = 2'b11
    } tamano_t;

    typedef enum logic [2:0] {
        AZUCAR_NINGUNO = 3'b000,
        AZUCAR_MIN     = 3'b001,
        AZUCAR_MAX     = 3'b110
    } azucar_t;

    typedef enum logic [1:0] {
        LIBRE   = 2'b00,
        ASIGNAR = 2'b01,
        ATENDER = 2'b10,
        LIBERAR = 2'b11
    } estado_t;

    localparam logic [7:0] TIMEOUT_DEF = 8'd64;

    function automatic logic [1:0] a_onehot(input logic panel);
        return panel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_prioridad.sv
// Two-requester round-robin picker: panel ptr wins a tie, otherwise the
// sole requester wins.
module rr_prioridad (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       winner,
    output logic       valid
);

    assign valid  = |req;
    assign winner = (req == 2'b11) ? ptr : req[1];

endmodule

// File: rtl/arbitro_maquina.sv
// Arbiter sharing one coffee machine between two panels, with watchdog.
// Define ARBITRO_ESTADISTICAS_EN to add per-panel served-drink counters.
module arbitro_maquina
    import maquina_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [2:0] tipo_cafe_0,
    input  logic [2:0] tipo_cafe_1,
    input  logic [1:0] tamano_0,
    input  logic [1:0] tamano_1,
    input  logic [2:0] nivel_azucar_0,
    input  logic [2:0] nivel_azucar_1,
    input  logic       pago_0,
    input  logic       pago_1,
    input  logic       seleccion_valida_in,
    input  logic       preparando_in,
    input  logic       listo_in,
    output logic [2:0] tipo_cafe_out,
    output logic [1:0] tamano_out,
    output logic [2:0] nivel_azucar_out,
    output logic       pago_out,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       ocupado
`ifdef ARBITRO_ESTADISTICAS_EN
    ,
    output logic [7:0] servidos_0,
    output logic [7:0] servidos_1
`endif
);

    estado_t    estado, estado_sig;
    logic       owner, owner_sig;
    logic       ptr, ptr_sig;
    logic [7:0] wd, wd_sig, wd_mas;
    logic [1:0] done_sig, err_sig;
    logic       rr_winner, rr_valid;
    logic       expira;
    logic       sirviendo;

    rr_prioridad u_rr (
        .req    (req),
        .ptr    (ptr),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    assign wd_mas = (wd == 8'hFF) ? wd : wd + 8'd1;
    assign expira = (wd_mas >= TIMEOUT);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        estado_sig = estado;
        owner_sig  = owner;
        ptr_sig    = ptr;
        wd_sig     = wd;
        done_sig   = 2'b00;
        err_sig    = 2'b00;
        case (estado)
            LIBRE: begin
                if (rr_valid) begin
                    owner_sig  = rr_winner;
                    estado_sig = ASIGNAR;
                end
            end
            ASIGNAR: begin
                wd_sig     = 8'd0;
                estado_sig = ATENDER;
            end
            ATENDER: begin
                wd_sig = wd_mas;
                // A finished drink beats both abandonment and watchdog expiry.
                if (listo_in) begin
                    done_sig   = a_onehot(owner);
                    estado_sig = LIBERAR;
                end else if (!preparando_in && (!req[owner] || expira)) begin
                    err_sig    = a_onehot(owner);
                    estado_sig = LIBERAR;
                end
            end
            LIBERAR: begin
                ptr_sig    = ~owner;
                owner_sig  = 1'b0;
                estado_sig = LIBRE;
            end
            default: estado_sig = LIBRE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= LIBRE;
            owner  <= 1'b0;
            ptr    <= 1'b0;
            wd     <= 8'd0;
            done   <= 2'b00;
            err    <= 2'b00;
`ifdef ARBITRO_ESTADISTICAS_EN
            servidos_0 <= 8'd0;
            servidos_1 <= 8'd0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            estado <= estado_sig;
            owner  <= owner_sig;
            ptr    <= ptr_sig;
            wd     <= wd_sig;
            done   <= done_sig;
            err    <= err_sig;
`ifdef ARBITRO_ESTADISTICAS_EN
            if (done_sig[0]) servidos_0 <= servidos_0 + 8'd1;
            if (done_sig[1]) servidos_1 <= servidos_1 + 8'd1;
`endif
        end
    end

    // The machine only ever sees the owner's selection; otherwise it idles.
    assign sirviendo        = (estado == ASIGNAR) || (estado == ATENDER);
    assign tipo_cafe_out    = sirviendo ? (owner ? tipo_cafe_1 : tipo_cafe_0) : 3'b000;
    assign tamano_out       = sirviendo ? (owner ? tamano_1 : tamano_0) : 2'b00;
    assign nivel_azucar_out = sirviendo ? (owner ? nivel_azucar_1 : nivel_azucar_0) : 3'b000;
    assign pago_out         = sirviendo ? (owner ? pago_1 : pago_0) : 1'b0;

    assign gnt     = (estado == ATENDER) ? a_onehot(owner) : 2'b00;
    assign ocupado = (estado == ATENDER);

    // Selection-valid status is informational for the panels, not for arbitration.
    logic unused_ok;
    assign unused_ok = seleccion_valida_in;

endmodule

// File: tb/tb_arbitro_maquina.sv
// Randomized scoreboard bench for arbitro_maquina with a transaction-level
// model of round-robin ownership, outcomes and served counters.
module tb_arbitro_maquina;
    import maquina_pkg::*;

    localparam logic [7:0] TO = 8'd16;
    localparam int K_LISTO    = 0;
    localparam int K_ABANDONO = 1;
    localparam int K_TIMEOUT  = 2;
    localparam int K_ESPERA   = 3;
    localparam int K_COINCIDE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [2:0] tipo_cafe_0, tipo_cafe_1;
    logic [1:0] tamano_0, tamano_1;
    logic [2:0] nivel_azucar_0, nivel_azucar_1;
    logic       pago_0, pago_1;
    logic       seleccion_valida_in, preparando_in, listo_in;
    logic [2:0] tipo_cafe_out;
    logic [1:0] tamano_out;
    logic [2:0] nivel_azucar_out;
    logic       pago_out;
    logic [1:0] gnt, done, err;
    logic       ocupado;
`ifdef ARBITRO_ESTADISTICAS_EN
    logic [7:0] servidos_0, servidos_1;
`endif

    arbitro_maquina #(.TIMEOUT(TO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .tipo_cafe_0         (tipo_cafe_0),
        .tipo_cafe_1         (tipo_cafe_1),
        .tamano_0            (tamano_0),
        .tamano_1            (tamano_1),
        .nivel_azucar_0      (nivel_azucar_0),
        .nivel_azucar_1      (nivel_azucar_1),
        .pago_0              (pago_0),
        .pago_1              (pago_1),
        .seleccion_valida_in (seleccion_valida_in),
        .preparando_in       (preparando_in),
        .listo_in            (listo_in),
        .tipo_cafe_out       (tipo_cafe_out),
        .tamano_out          (tamano_out),
        .nivel_azucar_out    (nivel_azucar_out),
        .pago_out            (pago_out),
        .gnt                 (gnt),
        .done                (done),
        .err                 (err),
        .ocupado             (ocupado)
`ifdef ARBITRO_ESTADISTICAS_EN
        ,
        .servidos_0          (servidos_0),
        .servidos_1          (servidos_1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] done;
        logic [1:0] err;
    } pulso_t;

    pulso_t     sb[$];
    int         checks = 0;
    int         errors = 0;
    logic       m_ptr;
    logic [7:0] m_serv[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion/abort pulses are matched against the scoreboard whenever they appear.
    always @(negedge clk) begin
        pulso_t p;
        if (done != 2'b00 || err != 2'b00) begin
            check("done_err_exclusivos", 32'(done & err), 0);
            if (sb.size() == 0) begin
                check("pulso_inesperado", 32'({done, err}), 0);
            end else begin
                p = sb.pop_front();
                check("pulso", 32'({done, err}), 32'({p.done, p.err}));
            end
        end
    end

    task automatic aleatorizar();
        tipo_cafe_0    = 3'($urandom_range(int'(CAFE_NEGRO), int'(CAFE_CAPUCHINO)));
        tipo_cafe_1    = 3'($urandom_range(int'(CAFE_NEGRO), int'(CAFE_CAPUCHINO)));
        tamano_0       = 2'($urandom_range(int'(TAM_CHICO), int'(TAM_GRANDE)));
        tamano_1       = 2'($urandom_range(int'(TAM_CHICO), int'(TAM_GRANDE)));
        nivel_azucar_0 = 3'($urandom_range(int'(AZUCAR_MIN), int'(AZUCAR_MAX)));
        nivel_azucar_1 = 3'($urandom_range(int'(AZUCAR_MIN), int'(AZUCAR_MAX)));
        pago_0         = 1'($urandom_range(0, 1));
        pago_1         = 1'($urandom_range(0, 1));
    endtask

    task automatic check_espejo(input logic w);
        check("tipo_out", 32'(tipo_cafe_out), 32'(w ? tipo_cafe_1 : tipo_cafe_0));
        check("tamano_out", 32'(tamano_out), 32'(w ? tamano_1 : tamano_0));
        check("azucar_out", 32'(nivel_azucar_out), 32'(w ? nivel_azucar_1 : nivel_azucar_0));
        check("pago_out", 32'(pago_out), 32'(w ? pago_1 : pago_0));
    endtask

    task automatic check_reposo(input string name);
        check({name, "_gnt"}, 32'(gnt), 0);
        check({name, "_ocupado"}, 32'(ocupado), 0);
        check({name, "_maquina"}, 32'({tipo_cafe_out, tamano_out, nivel_azucar_out, pago_out}), 0);
    endtask

`ifdef ARBITRO_ESTADISTICAS_EN
    task automatic check_serv();
        check("servidos_0", 32'(servidos_0), 32'(m_serv[0]));
        check("servidos_1", 32'(servidos_1), 32'(m_serv[1]));
    endtask
`endif

    // One ownership episode, entered and left with the arbiter idle (#1 after an edge).
    task automatic txn(input logic [1:0] nuevo, input int kind, input int d);
        logic   w;
        int     n;
        pulso_t e;
        req = req | nuevo;
        w   = (req == 2'b11) ? m_ptr : req[1];
        aleatorizar();
        @(posedge clk); #1;
        check("gnt_en_asignar", 32'(gnt), 0);
        check_espejo(w);
        @(posedge clk); #1;
        check("ocupado", 32'(ocupado), 1);

        n = (kind == K_TIMEOUT || kind == K_COINCIDE) ? int'(TO) : d;
        e.done = 2'b00;
        e.err  = 2'b00;
        if (kind == K_ABANDONO || kind == K_TIMEOUT) e.err = w ? 2'b10 : 2'b01;
        else                                          e.done = w ? 2'b10 : 2'b01;
        sb.push_back(e);

        for (int c = 1; c <= n; c++) begin
            aleatorizar();
            case (kind)
                K_LISTO:  preparando_in = 1'($urandom_range(0, 1));
                K_ESPERA: preparando_in = 1'b1;
                default:  preparando_in = 1'b0;
            endcase
            listo_in = (c == n) && (kind == K_LISTO || kind == K_ESPERA || kind == K_COINCIDE);
            if (kind == K_ABANDONO && c == n) req[w] = 1'b0;
            if (kind == K_ESPERA && c == 1)   req[w] = 1'b0;
            #1;
            check("gnt_atender", 32'(gnt), 32'(w ? 2'b10 : 2'b01));
            check_espejo(w);
            @(posedge clk); #1;
        end

        listo_in      = 1'b0;
        preparando_in = 1'b0;
        req[w]        = 1'b0;
        check_reposo("liberar");
        m_ptr = ~w;
        if (e.done != 2'b00) m_serv[w] = m_serv[w] + 8'd1;
        @(posedge clk); #1;
        check("pulso_pendiente", 32'(sb.size()), 0);
`ifdef ARBITRO_ESTADISTICAS_EN
        check_serv();
`endif
    endtask

    initial begin
        reset = 1'b0;
        req = 2'b00;
        preparando_in = 1'b0;
        listo_in = 1'b0;
        seleccion_valida_in = 1'b0;
        aleatorizar();
        m_ptr = 1'b0;
        m_serv[0] = 8'd0;
        m_serv[1] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reposo("reset");
        check("reset_pulsos", 32'({done, err}), 0);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reposo("libre_inicial");

        // Single panel, then tie handling and the alternating pointer.
        txn(2'b01, K_LISTO, 5);
        txn(2'b11, K_LISTO, 3);
        txn(2'b00, K_LISTO, 2);
        txn(2'b11, K_LISTO, 2);
        txn(2'b00, K_LISTO, 1);

        // Abort paths, held ownership while preparing, and the listo/expiry race.
        txn(2'b01, K_TIMEOUT, 0);
        txn(2'b10, K_ABANDONO, 4);
        txn(2'b01, K_ESPERA, 20);
        txn(2'b10, K_COINCIDE, 0);

        // Reset in the middle of a service aborts without any pulse.
        req = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        preparando_in = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reposo("reset_atender");
        check("reset_atender_pulsos", 32'({done, err}), 0);
        req = 2'b00;
        preparando_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        m_ptr = 1'b0;
        m_serv[0] = 8'd0;
        m_serv[1] = 8'd0;
        @(posedge clk); #1;
        txn(2'b10, K_LISTO, 3);
        txn(2'b11, K_LISTO, 2);
        txn(2'b00, K_LISTO, 2);

        for (int i = 0; i < 40; i++) begin
            int k;
            k = $urandom_range(0, 4);
            txn(2'($urandom_range(1, 3)), k,
                (k == K_ESPERA) ? $urandom_range(2, 24) : $urandom_range(1, 10));
        end

`ifdef ARBITRO_ESTADISTICAS_EN
        for (int i = 0; i < 260; i++) txn(2'b01, K_LISTO, 1);
`endif

        check("scoreboard_vacio", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
